// File: rtl/ac97_pkg.sv
// Shared AC97 frame constants, tag bit positions and receiver state encoding.
package ac97_pkg;

   localparam int AC97_FRAME_BITS  = 256;
   localparam int AC97_TAG_BITS    = 16;
   localparam int AC97_SLOT_BITS   = 20;

   localparam int AC97_SLOT1_START = 16;
   localparam int AC97_SLOT2_START = 36;
   localparam int AC97_SLOT3_START = 56;
   localparam int AC97_SLOT4_START = 76;

   localparam int AC97_TAG_READY   = 15;
   localparam int AC97_TAG_SLOT1   = 14;
   localparam int AC97_TAG_SLOT2   = 13;
   localparam int AC97_TAG_SLOT3   = 12;
   localparam int AC97_TAG_SLOT4   = 11;

   typedef logic [1:0] ac97_state_t;
   localparam ac97_state_t ST_HUNT      = 2'd0;
   localparam ac97_state_t ST_TAG       = 2'd1;
   localparam ac97_state_t ST_SLOTS     = 2'd2;
   localparam ac97_state_t ST_FRAME_END = 2'd3;

   // Frame bit index of the last bit of the slot starting at 'start'.
   function automatic logic [7:0] slot_last_bit(input int start);
      return 8'(start + AC97_SLOT_BITS - 1);
   endfunction

endpackage

// File: rtl/ac97_frame_sync.sv
// SYNC edge detection, frame bit counter, lock state machine and sticky sync_error.
module ac97_frame_sync
   import ac97_pkg::*;
(
   input  logic       bit_clk,
   input  logic       reset_b,
   input  logic       sync,
   output logic [7:0] bit_idx,
   output logic       bit_vld,
   output logic       sync_error
);

   logic        sync_q;
   ac97_state_t state_q, state_d;
   logic [7:0]  bit_cnt_q, bit_cnt_d;
   logic        sync_error_q, sync_error_d;
   logic        sync_rise_s;

   assign sync_rise_s = sync & ~sync_q;

   // Next state; bit_idx/bit_vld qualify the bit sampled at the coming edge.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      sync_error_d = sync_error_q;
      bit_idx      = bit_cnt_q;
      bit_vld      = 1'b0;
      case (state_q)
         ST_HUNT: begin
            if (sync_rise_s) begin
               state_d   = ST_TAG;
               bit_cnt_d = 8'd1;
               bit_idx   = 8'd0;
               bit_vld   = 1'b1;
            end else begin
               bit_cnt_d = 8'd0;
            end
         end
         ST_TAG, ST_SLOTS: begin
            bit_vld = 1'b1;
            if (sync_rise_s) begin
               // Early SYNC: this bit restarts the frame as bit 0.
               sync_error_d = 1'b1;
               state_d      = ST_TAG;
               bit_cnt_d    = 8'd1;
               bit_idx      = 8'd0;
            end else if (bit_cnt_q == 8'(AC97_FRAME_BITS - 1)) begin
               state_d   = ST_FRAME_END;
               bit_cnt_d = 8'd0;
            end else if (bit_cnt_q == 8'(AC97_TAG_BITS - 1)) begin
               state_d   = ST_SLOTS;
               bit_cnt_d = bit_cnt_q + 8'd1;
            end else begin
               bit_cnt_d = bit_cnt_q + 8'd1;
            end
         end
         ST_FRAME_END: begin
            if (sync_rise_s) begin
               state_d   = ST_TAG;
               bit_cnt_d = 8'd1;
               bit_idx   = 8'd0;
               bit_vld   = 1'b1;
            end else begin
               sync_error_d = 1'b1;
               state_d      = ST_HUNT;
               bit_cnt_d    = 8'd0;
            end
         end
         default: begin
            state_d   = ST_HUNT;
            bit_cnt_d = 8'd0;
         end
      endcase
   end

   // State, counter and SYNC history registers.
   always_ff @(posedge bit_clk or negedge reset_b) begin
      if (!reset_b) begin
         sync_q       <= 1'b0;
         state_q      <= ST_HUNT;
         bit_cnt_q    <= 8'd0;
         sync_error_q <= 1'b0;
      end else begin
         sync_q       <= sync;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         sync_error_q <= sync_error_d;
      end
   end

   assign sync_error = sync_error_q;

endmodule

// File: rtl/ac97_receiver.sv
// AC97 SDATA_IN deserializer: slot-0 tag decode, slot 3/4 PCM to FIFO, optional
// slot 1/2 status read-back enabled by defining AC97_RX_STATUS_EN.
module ac97_receiver
   import ac97_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 20
)(
   input  logic                      bit_clk,
   input  logic                      reset_b,
   input  logic                      sync,
   input  logic                      sdata_in,
   output logic [2*SAMPLE_WIDTH-1:0] sample_fifo_din,
   output logic                      sample_fifo_wr_en,
   input  logic                      sample_fifo_full,
   output logic                      codec_ready,
   output logic [6:0]                status_addr,
   output logic [15:0]               status_data,
   output logic                      status_valid,
   output logic                      overflow,
   output logic                      sync_error
);

   localparam logic [7:0] IDX_TAG_END = 8'(AC97_TAG_BITS - 1);
   localparam logic [7:0] IDX_L_END   = slot_last_bit(AC97_SLOT3_START);
   localparam logic [7:0] IDX_R_END   = slot_last_bit(AC97_SLOT4_START);

   logic [7:0] bit_idx_s;
   logic       bit_vld_s;

   ac97_frame_sync u_frame_sync (
      .bit_clk    (bit_clk),
      .reset_b    (reset_b),
      .sync       (sync),
      .bit_idx    (bit_idx_s),
      .bit_vld    (bit_vld_s),
      .sync_error (sync_error)
   );

   // Bit history plus the bit being sampled: word_s is the 20-bit slot (or, in its
   // low 16 bits, the tag) that ends at the current bit.
   logic [AC97_SLOT_BITS-2:0]   shift_q, shift_d;
   logic [AC97_SLOT_BITS-1:0]   word_s;
   logic                        codec_ready_q, codec_ready_d;
   logic                        pcm_ok_q, pcm_ok_d;
   logic [SAMPLE_WIDTH-1:0]     left_q, left_d;
   logic [2*SAMPLE_WIDTH-1:0]   din_q, din_d;
   logic                        wr_en_q, wr_en_d;
   logic                        overflow_q, overflow_d;

   assign word_s = {shift_q, sdata_in};

   // Tag latch, left capture and the FIFO write decision at the end of slot 4.
   always_comb begin
      shift_d       = word_s[AC97_SLOT_BITS-2:0];
      codec_ready_d = codec_ready_q;
      pcm_ok_d      = pcm_ok_q;
      left_d        = left_q;
      din_d         = din_q;
      wr_en_d       = 1'b0;
      overflow_d    = overflow_q;
      if (!bit_vld_s) begin
         wr_en_d = 1'b0;
      end else if (bit_idx_s == IDX_TAG_END) begin
         codec_ready_d = word_s[AC97_TAG_READY];
         pcm_ok_d      = word_s[AC97_TAG_SLOT3] & word_s[AC97_TAG_SLOT4];
      end else if (bit_idx_s == IDX_L_END) begin
         left_d = word_s[AC97_SLOT_BITS-1 -: SAMPLE_WIDTH];
      end else if (bit_idx_s == IDX_R_END) begin
         if (!pcm_ok_q) begin
            wr_en_d = 1'b0;
         end else if (sample_fifo_full) begin
            overflow_d = 1'b1;
         end else begin
            wr_en_d = 1'b1;
            din_d   = {left_q, word_s[AC97_SLOT_BITS-1 -: SAMPLE_WIDTH]};
         end
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Capture-path registers.
   always_ff @(posedge bit_clk or negedge reset_b) begin
      if (!reset_b) begin
         shift_q       <= '0;
         codec_ready_q <= 1'b0;
         pcm_ok_q      <= 1'b0;
         left_q        <= '0;
         din_q         <= '0;
         wr_en_q       <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         shift_q       <= shift_d;
         codec_ready_q <= codec_ready_d;
         pcm_ok_q      <= pcm_ok_d;
         left_q        <= left_d;
         din_q         <= din_d;
         wr_en_q       <= wr_en_d;
         overflow_q    <= overflow_d;
      end
   end

   assign sample_fifo_din   = din_q;
   assign sample_fifo_wr_en = wr_en_q;
   assign codec_ready       = codec_ready_q;
   assign overflow          = overflow_q;

`ifdef AC97_RX_STATUS_EN
   localparam logic [7:0] IDX_S1_END = slot_last_bit(AC97_SLOT1_START);
   localparam logic [7:0] IDX_S2_END = slot_last_bit(AC97_SLOT2_START);

   logic        stat_ok_q, stat_ok_d;
   logic [6:0]  addr_pend_q, addr_pend_d;
   logic [6:0]  status_addr_q, status_addr_d;
   logic [15:0] status_data_q, status_data_d;
   logic        status_valid_q, status_valid_d;

   // Address is held pending until slot 2 completes so both outputs move together.
   always_comb begin
      stat_ok_d      = stat_ok_q;
      addr_pend_d    = addr_pend_q;
      status_addr_d  = status_addr_q;
      status_data_d  = status_data_q;
      status_valid_d = 1'b0;
      if (!bit_vld_s) begin
         status_valid_d = 1'b0;
      end else if (bit_idx_s == IDX_TAG_END) begin
         stat_ok_d = word_s[AC97_TAG_SLOT1] & word_s[AC97_TAG_SLOT2];
      end else if (bit_idx_s == IDX_S1_END) begin
         addr_pend_d = word_s[18:12];
      end else if ((bit_idx_s == IDX_S2_END) && stat_ok_q) begin
         status_addr_d  = addr_pend_q;
         status_data_d  = word_s[19:4];
         status_valid_d = 1'b1;
      end else begin
         status_valid_d = 1'b0;
      end
   end

   // Status read-back registers.
   always_ff @(posedge bit_clk or negedge reset_b) begin
      if (!reset_b) begin
         stat_ok_q      <= 1'b0;
         addr_pend_q    <= 7'd0;
         status_addr_q  <= 7'd0;
         status_data_q  <= 16'd0;
         status_valid_q <= 1'b0;
      end else begin
         stat_ok_q      <= stat_ok_d;
         addr_pend_q    <= addr_pend_d;
         status_addr_q  <= status_addr_d;
         status_data_q  <= status_data_d;
         status_valid_q <= status_valid_d;
      end
   end

   assign status_addr  = status_addr_q;
   assign status_data  = status_data_q;
   assign status_valid = status_valid_q;
`else
   assign status_addr  = 7'd0;
   assign status_data  = 16'd0;
   assign status_valid = 1'b0;
`endif

endmodule

// File: tb/tb_ac97_receiver.sv
// Scoreboard bench for ac97_receiver: a 20-bit and a 16-bit instance share one
// SDATA_IN stream; expectations are derived from the frames as they are driven.
module tb_ac97_receiver;

   localparam int SW  = 20;
   localparam int SW2 = 16;

   logic bit_clk = 1'b0;
   logic reset_b = 1'b0;
   logic sync = 1'b0;
   logic sdata_in = 1'b0;
   logic full = 1'b0;

   logic [2*SW-1:0]  din;
   logic [2*SW2-1:0] din2;
   logic wr_en, wr2, ready, ready2, sv, sv2, ovf, ovf2, serr, serr2;
   logic [6:0]  addr, addr2;
   logic [15:0] data, data2;

   ac97_receiver #(.SAMPLE_WIDTH(SW)) dut (
      .bit_clk(bit_clk), .reset_b(reset_b), .sync(sync), .sdata_in(sdata_in),
      .sample_fifo_din(din), .sample_fifo_wr_en(wr_en), .sample_fifo_full(full),
      .codec_ready(ready), .status_addr(addr), .status_data(data),
      .status_valid(sv), .overflow(ovf), .sync_error(serr));

   ac97_receiver #(.SAMPLE_WIDTH(SW2)) dut16 (
      .bit_clk(bit_clk), .reset_b(reset_b), .sync(sync), .sdata_in(sdata_in),
      .sample_fifo_din(din2), .sample_fifo_wr_en(wr2), .sample_fifo_full(full),
      .codec_ready(ready2), .status_addr(addr2), .status_data(data2),
      .status_valid(sv2), .overflow(ovf2), .sync_error(serr2));

   always #5 bit_clk = ~bit_clk;

   typedef struct packed {
      logic [2*SW-1:0]  d20;
      logic [2*SW2-1:0] d16;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int errors = 0;

   logic        exp_wr = 1'b0, exp_ready = 1'b0, exp_sv = 1'b0;
   logic        exp_ovf = 1'b0, exp_serr = 1'b0;
   logic [6:0]  exp_addr = 7'd0;
   logic [15:0] exp_data = 16'd0;
   logic        locked = 1'b0;
   int          prev_len = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      chk("wr_en", {63'd0, wr_en}, {63'd0, exp_wr});
      chk("wr_en16", {63'd0, wr2}, {63'd0, exp_wr});
      if (wr_en === 1'b1) begin
         chk("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("din", {24'd0, din}, {24'd0, e.d20});
            chk("din16", {32'd0, din2}, {32'd0, e.d16});
         end
      end
      chk("codec_ready", {63'd0, ready}, {63'd0, exp_ready});
      chk("overflow", {63'd0, ovf}, {63'd0, exp_ovf});
      chk("overflow16", {63'd0, ovf2}, {63'd0, exp_ovf});
      chk("sync_error", {63'd0, serr}, {63'd0, exp_serr});
      chk("status_valid", {63'd0, sv}, {63'd0, exp_sv});
      chk("status_addr", {57'd0, addr}, {57'd0, exp_addr});
      chk("status_data", {48'd0, data}, {48'd0, exp_data});
   endtask

   // One bit period: check what the previous edge produced, then drive the next bit.
   task automatic step(input logic s, input logic d, input logic f);
      @(negedge bit_clk);
      monitor();
      exp_wr   = 1'b0;
      exp_sv   = 1'b0;
      sync     = s;
      sdata_in = d;
      full     = f;
   endtask

   task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1,
                             input logic [19:0] s2, input logic [19:0] l,
                             input logic [19:0] r, input int nbits, input logic f);
      logic [95:0] fb;
      logic        d;
      exp_t        e;
      fb = {tag, s1, s2, l, r};
      for (int i = 0; i < nbits; i++) begin
         d = (i < 96) ? fb[95-i] : 1'($urandom_range(0, 1));
         step(i < 16, d, f);
         if (i == 0 && locked && prev_len < 256) exp_serr = 1'b1;
         if (i == 15) exp_ready = tag[15];
`ifdef AC97_RX_STATUS_EN
         if (i == 55 && tag[14] && tag[13]) begin
            exp_sv   = 1'b1;
            exp_addr = s1[18:12];
            exp_data = s2[19:4];
         end
`endif
         if (i == 95 && tag[12] && tag[11]) begin
            if (f) begin
               exp_ovf = 1'b1;
            end else begin
               exp_wr = 1'b1;
               e.d20  = {l, r};
               e.d16  = {l[19:4], r[19:4]};
               sb.push_back(e);
            end
         end
      end
      locked   = 1'b1;
      prev_len = nbits;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (i == 0 && locked && prev_len == 256) exp_serr = 1'b1;
      end
      locked = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) step(1'b0, 1'b0, 1'b0);
      chk("rst_din", {24'd0, din}, 64'd0);
      reset_b = 1'b1;
      idle(5);

      // Nominal frames, status read-back, tag variants
      repeat (3) send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'h0ABCD, 256, 1'b0);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h5A5A5, 20'hC3C3C, 256, 1'b0);
      send_frame(16'h9800, 20'h11000, 20'h12340, 20'h55555, 20'hAAAAA, 256, 1'b0);
      send_frame(16'hE000, 20'h7F000, 20'hBEEF0, 20'h11111, 20'h22222, 256, 1'b0);
      send_frame(16'hF000, 20'h26000, 20'h000F0, 20'h33333, 20'h44444, 256, 1'b0);

      // FIFO full: no write, sticky overflow
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h66666, 20'h77777, 256, 1'b1);
      repeat (2) send_frame(16'hF800, 20'h01000, 20'h00010, 20'h89ABC, 20'hDEF01, 256, 1'b0);

      // Early SYNC before and after the slot-4 end, then correct decode
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'hAAAA5, 20'h5AAAA, 80, 1'b0);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'h0ABCD, 256, 1'b0);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'hFEDCB, 20'hA9876, 100, 1'b0);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'h0ABCD, 256, 1'b0);

      // Missing SYNC at bit 256, then relock
      idle(20);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h13579, 20'h2468A, 256, 1'b0);

      // Reset asserted mid-frame at bit 70
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'h0ABCD, 70, 1'b0);
      @(negedge bit_clk);
      monitor();
      reset_b = 1'b0;
      sync    = 1'b0;
      #1;
      chk("rst_mid_wr_en", {63'd0, wr_en}, 64'd0);
      chk("rst_mid_din", {24'd0, din}, 64'd0);
      chk("rst_mid_ready", {63'd0, ready}, 64'd0);
      chk("rst_mid_overflow", {63'd0, ovf}, 64'd0);
      chk("rst_mid_sync_error", {63'd0, serr}, 64'd0);
      chk("rst_mid_status_addr", {57'd0, addr}, 64'd0);
      chk("rst_mid_status_data", {48'd0, data}, 64'd0);
      exp_wr = 1'b0; exp_ready = 1'b0; exp_sv = 1'b0; exp_ovf = 1'b0; exp_serr = 1'b0;
      exp_addr = 7'd0; exp_data = 16'd0;
      locked = 1'b0;
      sb.delete();
      repeat (3) step(1'b0, 1'b0, 1'b0);
      reset_b = 1'b1;
      idle(3);
      send_frame(16'hF800, 20'h26000, 20'h000F0, 20'h12345, 20'h0ABCD, 256, 1'b0);
      idle(4);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
